// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM port between two requesters,
// with bounded bursts and per-requester read responses one cycle after acceptance.
module ram_port_arbiter #(
  parameter int WIDTH     = 8,
  parameter int LG_DEPTH  = 6,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic [LG_DEPTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]    req0_wdata,
  output logic                rsp0_valid,
  output logic [WIDTH-1:0]    rsp0_rdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic [LG_DEPTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]    req1_wdata,
  output logic                rsp1_valid,
  output logic [WIDTH-1:0]    rsp1_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [LG_DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0]    ram_wdata,
  input  logic [WIDTH-1:0]    ram_rdata
);

  localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             last_r, last_nxt_s;
  logic             xfer0_s, xfer1_s;
  logic             rsp0_valid_r, rsp1_valid_r;

  assign req0_ready = (state_r == ST_GRANT0);
  assign req1_ready = (state_r == ST_GRANT1);
  assign xfer0_s    = req0_ready & req0_valid;
  assign xfer1_s    = req1_ready & req1_valid;

  // RAM port driven straight from the current owner's command
  always_comb begin
    ram_en    = xfer0_s | xfer1_s;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_r == ST_GRANT0) begin
      ram_we    = xfer0_s & req0_we;
      ram_addr  = req0_addr;
      ram_wdata = req0_wdata;
    end else if (state_r == ST_GRANT1) begin
      ram_we    = xfer1_s & req1_we;
      ram_addr  = req1_addr;
      ram_wdata = req1_wdata;
    end else begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  // Arbitration: tie goes to the requester that did not own the port last
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          state_nxt_s = last_r ? ST_GRANT0 : ST_GRANT1;
        end else if (req0_valid) begin
          state_nxt_s = ST_GRANT0;
        end else if (req1_valid) begin
          state_nxt_s = ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (xfer0_s) begin
          if (cnt_r != CNT_LAST) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_nxt_s = '0;
            if (req1_valid) begin
              state_nxt_s = ST_GRANT1;
              last_nxt_s  = 1'b0;
            end else begin
              state_nxt_s = ST_GRANT0;
            end
          end
        end else begin
          cnt_nxt_s   = '0;
          last_nxt_s  = 1'b0;
          state_nxt_s = req1_valid ? ST_GRANT1 : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (xfer1_s) begin
          if (cnt_r != CNT_LAST) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_nxt_s = '0;
            if (req0_valid) begin
              state_nxt_s = ST_GRANT0;
              last_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_GRANT1;
            end
          end
        end else begin
          cnt_nxt_s   = '0;
          last_nxt_s  = 1'b1;
          state_nxt_s = req0_valid ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
        last_nxt_s  = 1'b1;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Response tag captured at acceptance so an owner switch cannot lose it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      rsp0_valid_r <= xfer0_s & ~req0_we;
      rsp1_valid_r <= xfer1_s & ~req1_we;
    end
  end

  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_rdata = rsp0_valid_r ? ram_rdata : '0;
  assign rsp1_rdata = rsp1_valid_r ? ram_rdata : '0;

endmodule
